ui_debounce: RTL and testbench

Input conditioning stage that sits directly upstream of the `silly1` core and drives its `ui_in` bus. It synchronises each raw pad bit through two flops and debounces it with a per-bit stability counter. It presents a clean registered byte, plus optional one-cycle rise/fall/change strobes. The pads are asynchronous, mechanical switch inputs; this block is the only place they are touched.

---
 rtl/ui_debounce.sv | 96 +++++++++
 tb/tb_ui_debounce.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ui_debounce.sv
// ui_debounce: two-flop synchroniser plus per-bit stability counter for
// mechanical switch pads. Presents a clean registered level on dout and,
// when UI_DEBOUNCE_STROBES_EN is defined, one-cycle rise/fall/changed strobes.
// With UI_DEBOUNCE_STROBES_EN undefined the strobe outputs are tied to 0 and
// the port list is unchanged.
module ui_debounce #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] dout_nxt;

  // Two-flop synchroniser; only s2 is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Per-bit stability count: clear on agreement, flip-and-clear at the
  // terminal count, so the counter never wraps.
  always_comb begin
    dout_nxt = dout;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != dout[i]) begin
        if (cnt[i] == CNT_LAST) begin
          dout_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level and counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      dout <= dout_nxt;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef UI_DEBOUNCE_STROBES_EN
  logic [WIDTH-1:0] flip;

  // Bits that flip at the coming edge.
  always_comb begin
    flip = dout ^ dout_nxt;
  end

  // Edge strobes registered on the same edge that updates dout; reset never strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      rise    <= flip & dout_nxt;
      fall    <= flip & dout;
      changed <= |flip;
    end
  end
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_ui_debounce.sv
// Self-checking bench for ui_debounce with WIDTH=8, DB_CYCLES=4.
module tb_ui_debounce;

  localparam int unsigned W  = 8;
  localparam int unsigned DB = 4;
`ifdef UI_DEBOUNCE_STROBES_EN
  localparam bit STB = 1'b1;
`else
  localparam bit STB = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] dout;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] dout, rise, fall;
  logic       changed;

  int n_vec = 0;
  int n_err = 0;

  exp_t sb[$];

  // Reference model state
  logic [7:0] m_s1 = '0, m_s2 = '0, m_dout = '0;
  int         m_run [8];

  ui_debounce #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after the coming edge: a bit flips after DB consecutive
  // synchronised samples that disagree with the current level.
  task automatic model_step(input logic [7:0] d, input logic r, output exp_t e);
    logic [7:0] nd;
    e = '0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_dout = '0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      return;
    end
    nd = m_dout;
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] != m_dout[i]) begin
        m_run[i]++;
        if (m_run[i] >= int'(DB)) begin
          nd[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    e.dout    = nd;
    e.rise    = STB ? (nd & ~m_dout) : 8'h00;
    e.fall    = STB ? (~nd & m_dout) : 8'h00;
    e.changed = STB ? (nd != m_dout) : 1'b0;
    m_s2   = m_s1;
    m_s1   = d;
    m_dout = nd;
  endtask

  // Drive one cycle, push the expectation, then compare after the edge.
  task automatic tick(input logic [7:0] d, input logic r);
    exp_t e;
    din = d;
    rst = r;
    model_step(d, r, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("dout", dout, e.dout);
      chk("rise", rise, e.rise);
      chk("fall", fall, e.fall);
      chk("changed", changed, e.changed);
    end
  endtask

  int first, hits, n_rise;

  initial begin
    for (int i = 0; i < 8; i++) m_run[i] = 0;

    // Reset
    tick(8'h00, 1'b1);
    tick(8'h00, 1'b1);
    chk("reset_dout", dout, 8'h00);
    chk("reset_changed", changed, 1'b0);

    // Clean step 0x00 -> 0x01
    for (int k = 1; k <= 7; k++) begin
      tick(8'h01, 1'b0);
      if (k == 5) chk("clean_dout_e5", dout, 8'h00);
      if (k == 6) begin
        chk("clean_dout_e6", dout, 8'h01);
        chk("clean_rise_e6", rise, STB ? 8'h01 : 8'h00);
        chk("clean_fall_e6", fall, 8'h00);
        chk("clean_chg_e6", changed, STB);
      end
      if (k == 7) begin
        chk("clean_rise_e7", rise, 8'h00);
        chk("clean_chg_e7", changed, 1'b0);
      end
    end

    // Reset while dout=1 must not strobe
    tick(8'h00, 1'b1);
    chk("rst_hi_dout", dout, 8'h00);
    chk("rst_hi_fall", fall, 8'h00);

    // Glitch of 3 cycles on bit 3: no activity
    hits = 0;
    for (int k = 1; k <= 23; k++) begin
      tick((k <= 3) ? 8'h08 : 8'h00, 1'b0);
      if (dout != 8'h00 || changed) hits++;
    end
    chk("glitch3_activity", hits, 0);

    // 4-cycle pulse on bit 3: dout=0x08 for exactly 4 cycles from edge 6
    hits = 0; first = 0;
    for (int k = 1; k <= 16; k++) begin
      tick((k <= 4) ? 8'h08 : 8'h00, 1'b0);
      if (dout == 8'h08) begin
        hits++;
        if (first == 0) first = k;
      end
    end
    chk("pulse4_first", first, 6);
    chk("pulse4_len", hits, 4);

    // Bring dout to 0x01, then swap to 0x80 in one step
    for (int k = 1; k <= 6; k++) tick(8'h01, 1'b0);
    chk("pre_swap_dout", dout, 8'h01);
    for (int k = 1; k <= 7; k++) begin
      tick(8'h80, 1'b0);
      if (k == 6) begin
        chk("swap_dout", dout, 8'h80);
        chk("swap_rise", rise, STB ? 8'h80 : 8'h00);
        chk("swap_fall", fall, STB ? 8'h01 : 8'h00);
        chk("swap_chg", changed, STB);
      end
      if (k == 7) chk("swap_chg_off", changed, 1'b0);
    end

    // Bounce on bit 0
    tick(8'h00, 1'b1);
    for (int k = 1; k <= 3; k++) tick(8'h00, 1'b0);
    begin
      logic [8:0] pat;
      pat = 9'b111101101;  // bit k-1 is the value for tick k
      n_rise = 0; first = 0;
      for (int k = 1; k <= 19; k++) begin
        tick((k <= 9) ? {7'd0, pat[k-1]} : 8'h01, 1'b0);
        if (rise[0]) n_rise++;
        if (dout[0] && first == 0) first = k;
      end
    end
    chk("bounce_flip_edge", first, 11);
    chk("bounce_rise_count", n_rise, STB ? 1 : 0);
    chk("bounce_dout", dout, 8'h01);

    // Reset mid-count, then the flip completes 6 edges after release
    for (int k = 1; k <= 10; k++) begin
      tick(8'hFF, (k == 4));
      if (k == 4) begin
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_fall", fall, 8'h00);
        chk("midrst_chg", changed, 1'b0);
      end
      if (k == 9) chk("midrst_dout_e9", dout, 8'h00);
      if (k == 10) begin
        chk("midrst_dout_e10", dout, 8'hFF);
        chk("midrst_rise_e10", rise, STB ? 8'hFF : 8'h00);
      end
    end
    tick(8'hFF, 1'b0);
    chk("midrst_rise_off", rise, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
